esm_dep_scheduler: RTL and testbench

Parametrised successor to the ESM dependency-tracking core. Accepts one decoded RISC-V instruction per cycle into a `bs`-entry in-flight window and records RAW (and optionally WAW) dependencies in a per-slot dependency matrix. Issues dependency-free entries through a valid/ready handshake with round-robin fairness, and frees slots and dependency columns on completion. It sits between decode and the execution units of the ESM pipeline.

---
 rtl/esm_dep_scheduler.sv | 125 ++++++++++++
 tb/tb_esm_dep_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/esm_dep_scheduler.sv
// esm_dep_scheduler: in-flight window with dependency matrix, round-robin issue and completion wakeup
module esm_dep_scheduler #(
  parameter int Instr_word_size = 32,
  parameter int regnum = 32,
  parameter int bs = 16,
  parameter bit WAW_EN = 1'b1,
  localparam int reg_addr_bits = $clog2(regnum),
  localparam int bs_bits = $clog2(bs)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [Instr_word_size-1:0] Instr_in,
  input  logic                       ALUSrc,
  input  logic                       RegWrite,
  output logic [bs_bits-1:0]         alloc_index,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [bs_bits-1:0]         ready_index,
  input  logic                       cmpl_valid,
  input  logic [bs_bits-1:0]         cmpl_index,
  output logic [bs_bits:0]           occupancy,
  output logic                       cmpl_err
);
  typedef enum logic [1:0] {FREE, WAIT, ISSUED} slot_t;
  slot_t                    st [bs];
  slot_t                    st_n [bs];
  logic [bs-1:0]            dep [bs];
  logic [bs-1:0]            dep_n [bs];
  logic                     pv [regnum];
  logic                     pv_n [regnum];
  logic [bs_bits-1:0]       pw [regnum];
  logic [bs_bits-1:0]       pw_n [regnum];
  logic [bs_bits-1:0]       rr_ptr;
  logic [bs-1:0]            rdy;
  logic [bs-1:0]            new_row;
  logic [reg_addr_bits-1:0] rs1, rs2, rd;
  logic                     disp, hs, cmpl_ok;
  logic                     unused_bits;
  assign rs1 = Instr_in[15 +: reg_addr_bits];
  assign rs2 = ALUSrc ? Instr_in[20 +: reg_addr_bits] : '0;
  assign rd = RegWrite ? Instr_in[7 +: reg_addr_bits] : '0;
  assign unused_bits = ^{Instr_in[Instr_word_size-1:25], Instr_in[14:12], Instr_in[6:0]};
  assign in_ready = occupancy != (bs_bits+1)'(bs);
  assign disp = in_valid && in_ready;
  assign hs = issue_valid && issue_ready;
  assign cmpl_ok = cmpl_valid && st[cmpl_index] == ISSUED;
  // occupancy count, ready vector and lowest free slot, all from registered state
  always_comb begin
    occupancy = '0;
    alloc_index = '0;
    for (int s = bs - 1; s >= 0; s--) begin
      occupancy = occupancy + (bs_bits+1)'(st[s] != FREE);
      rdy[s] = st[s] == WAIT && dep[s] == '0;
      if (st[s] == FREE) alloc_index = bs_bits'(s);
    end
  end
  // first ready slot searching circularly from rr_ptr
  always_comb begin
    issue_valid = 1'b0;
    ready_index = '0;
    for (int i = 0; i < bs; i++) begin
      if (!issue_valid && rdy[rr_ptr + bs_bits'(i)]) begin
        issue_valid = 1'b1;
        ready_index = rr_ptr + bs_bits'(i);
      end
    end
  end
  // dependency row of the dispatching instruction; a producer completing this cycle is bypassed
  always_comb begin
    new_row = '0;
    if (pv[rs1]) new_row[pw[rs1]] = 1'b1;
    if (pv[rs2]) new_row[pw[rs2]] = 1'b1;
    if (WAW_EN && pv[rd]) new_row[pw[rd]] = 1'b1;
    if (cmpl_ok) new_row[cmpl_index] = 1'b0;
  end
  // next slot state and dependency rows; dispatch targets a FREE slot so it never collides with issue or completion
  always_comb begin
    for (int s = 0; s < bs; s++) begin
      st_n[s] = st[s];
      dep_n[s] = dep[s];
      if (cmpl_ok) dep_n[s][cmpl_index] = 1'b0;
      if (hs && ready_index == bs_bits'(s)) st_n[s] = ISSUED;
      if (cmpl_ok && cmpl_index == bs_bits'(s)) st_n[s] = FREE;
      if (disp && alloc_index == bs_bits'(s)) begin
        st_n[s] = WAIT;
        dep_n[s] = new_row;
      end
    end
  end
  // producer table: completion invalidates, a new writer of the same register wins
  always_comb begin
    for (int r = 0; r < regnum; r++) begin
      pv_n[r] = pv[r] && !(cmpl_ok && pw[r] == cmpl_index);
      pw_n[r] = pw[r];
      if (disp && rd != '0 && rd == reg_addr_bits'(r)) begin
        pv_n[r] = 1'b1;
        pw_n[r] = alloc_index;
      end
    end
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < bs; s++) begin
        st[s] <= FREE;
        dep[s] <= '0;
      end
      for (int r = 0; r < regnum; r++) begin
        pv[r] <= 1'b0;
        pw[r] <= '0;
      end
      rr_ptr <= '0;
      cmpl_err <= 1'b0;
    end else begin
      st <= st_n;
      dep <= dep_n;
      pv <= pv_n;
      pw <= pw_n;
      rr_ptr <= hs ? ready_index + 1'b1 : rr_ptr;
      cmpl_err <= cmpl_err || (cmpl_valid && !cmpl_ok);
    end
  end
endmodule

// File: tb/tb_esm_dep_scheduler.sv
// tb_esm_dep_scheduler: directed self-checking bench for the dependency scheduler
module tb_esm_dep_scheduler;
  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 1'b0, ALUSrc = 1'b0, RegWrite = 1'b0, issue_ready = 1'b0, cmpl_valid = 1'b0;
  logic [31:0] Instr_in = '0;
  logic [3:0]  cmpl_index = '0;
  logic        in_ready, issue_valid, cmpl_err, r_in_ready, r_issue_valid, r_cmpl_err;
  logic [3:0]  alloc_index, ready_index, r_alloc_index, r_ready_index;
  logic [4:0]  occupancy, r_occupancy;
  int          n_chk = 0, n_fail = 0;

  esm_dep_scheduler #(.WAW_EN(1'b1)) u_waw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .Instr_in(Instr_in),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .alloc_index(alloc_index), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .ready_index(ready_index), .cmpl_valid(cmpl_valid),
    .cmpl_index(cmpl_index), .occupancy(occupancy), .cmpl_err(cmpl_err));

  esm_dep_scheduler #(.WAW_EN(1'b0)) u_raw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready), .Instr_in(Instr_in),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .alloc_index(r_alloc_index), .issue_valid(r_issue_valid),
    .issue_ready(issue_ready), .ready_index(r_ready_index), .cmpl_valid(cmpl_valid),
    .cmpl_index(cmpl_index), .occupancy(r_occupancy), .cmpl_err(r_cmpl_err));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    issue_ready = 1'b0;
    cmpl_valid = 1'b0;
  endtask

  task automatic disp(input int rd, input int rs1, input int rs2, input logic src);
    Instr_in = {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    ALUSrc = src;
    RegWrite = 1'b1;
    in_valid = 1'b1;
  endtask

  task automatic cmpl(input int i);
    cmpl_valid = 1'b1;
    cmpl_index = 4'(i);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_occ", occupancy, 0);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_alloc", alloc_index, 0);
    check("rst_ready_index", ready_index, 0);
    check("rst_cmpl_err", cmpl_err, 0);
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 16; i++) begin
      check("fill_alloc", alloc_index, i);
      disp(i + 1, 0, 0, 1'b0);
      cyc();
    end
    check("full_in_ready", in_ready, 0);
    check("full_occ", occupancy, 16);
    check("full_issue_valid", issue_valid, 1);
    disp(20, 0, 0, 1'b0);
    cyc();
    check("full_hold_occ", occupancy, 16);
    for (int i = 0; i < 4; i++) begin
      check("fill_rr", ready_index, i);
      issue_ready = 1'b1;
      cyc();
    end
    do_reset();

    disp(5, 1, 2, 1'b1);
    cyc();
    check("raw_alloc", alloc_index, 1);
    check("raw_first_offer", issue_valid, 1);
    disp(6, 5, 3, 1'b1);
    cyc();
    check("raw_ready0", ready_index, 0);
    check("raw_occ2", occupancy, 2);
    issue_ready = 1'b1;
    cyc();
    check("raw_blocked", issue_valid, 0);
    cmpl(0);
    cyc();
    check("raw_wake_valid", issue_valid, 1);
    check("raw_wake_index", ready_index, 1);
    check("raw_occ1", occupancy, 1);
    check("raw_no_err", cmpl_err, 0);
    do_reset();

    for (int i = 0; i < 4; i++) begin
      disp(i + 1, 0, 0, 1'b0);
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      check("rr_order", ready_index, i);
      issue_ready = 1'b1;
      cyc();
    end
    check("rr_next3", ready_index, 3);
    cmpl(0);
    cyc();
    check("rr_alloc0", alloc_index, 0);
    check("rr_occ3", occupancy, 3);
    disp(5, 0, 0, 1'b0);
    cyc();
    check("rr_occ4", occupancy, 4);
    check("rr_3_first", ready_index, 3);
    issue_ready = 1'b1;
    cyc();
    check("rr_then0_valid", issue_valid, 1);
    check("rr_then0", ready_index, 0);
    do_reset();

    disp(1, 0, 0, 1'b0);
    cyc();
    disp(3, 0, 0, 1'b0);
    cyc();
    disp(9, 0, 0, 1'b0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      check("byp_issue", ready_index, i);
      issue_ready = 1'b1;
      cyc();
    end
    check("byp_idle", issue_valid, 0);
    check("byp_alloc3", alloc_index, 3);
    cmpl(2);
    disp(10, 9, 0, 1'b1);
    cyc();
    check("byp_offer_valid", issue_valid, 1);
    check("byp_offer_index", ready_index, 3);
    check("byp_occ", occupancy, 3);
    check("byp_alloc2", alloc_index, 2);
    disp(11, 9, 0, 1'b1);
    cyc();
    check("byp_occ4", occupancy, 4);
    issue_ready = 1'b1;
    cyc();
    check("x9_invalid_valid", issue_valid, 1);
    check("x9_invalid_index", ready_index, 2);
    do_reset();

    cmpl(4);
    cyc();
    check("err_free", cmpl_err, 1);
    check("err_occ", occupancy, 0);
    cyc();
    cyc();
    check("err_sticky", cmpl_err, 1);
    disp(1, 0, 0, 1'b0);
    cyc();
    cmpl(0);
    cyc();
    check("err_wait_occ", occupancy, 1);
    check("err_wait_still_ready", issue_valid, 1);
    do_reset();

    disp(7, 0, 0, 1'b0);
    cyc();
    disp(7, 0, 0, 1'b0);
    cyc();
    check("waw_ready0", ready_index, 0);
    check("raw_only_ready0", r_ready_index, 0);
    issue_ready = 1'b1;
    cyc();
    check("waw_blocked", issue_valid, 0);
    check("raw_only_valid", r_issue_valid, 1);
    check("raw_only_index", r_ready_index, 1);
    cmpl(0);
    cyc();
    check("waw_wake_valid", issue_valid, 1);
    check("waw_wake_index", ready_index, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
